dmul_rot_sched: RTL and testbench
=================================

# dmul_rot_sched

Job scheduler for the rotation unary multiplier (dMUL_rot_uni). It accepts operand pairs over a valid/ready handshake and drives the multiplier's operand and load pins. It then counts the multiplier's output bitstream over a fixed window of 2^LOGLEN cycles and returns the one-count as the product over a second valid/ready handshake. It sits between the binary fabric and one multiplier instance, turning the unary datapath into a blocking, request/response binary multiplier.

## Interface
- DATAWD, 8: operand width; must match the multiplier.
- LOGLEN, 16: log2 of the counting window in cycles.
  - Legal range DATAWD..2*DATAWD.
  - LOGLEN = 2*DATAWD gives the exact product.

- clk  in  1  clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- iA  in  DATAWD  job operand A.
- iB  in  DATAWD  job operand B.
- iValid  in  1  job request.
- oReady  out  1  scheduler can accept a job.
- iFlush  in  1  synchronous abort of the current job.
- oMulA  out  DATAWD  operand A to the multiplier.
- oMulB  out  DATAWD  operand B to the multiplier.
- oLoadA  out  1  multiplier loadA.
- oLoadB  out  1  multiplier loadB.
- iMulC  in  1  multiplier output bitstream.
- oProd  out  LOGLEN+1  result count.
- oValid  out  1  result valid.
- iReady  in  1  result consumer ready.
- oBusy  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, LOAD, RUN, DONE. Reset enters IDLE.
- **IDLE**
  - oReady=1.
  - On iValid&oReady, latch iA/iB into the operand registers, clear the counters, and go to LOAD.
- **LOAD** (exactly 1 cycle)
  - oLoadA=oLoadB=1 and oMulA/oMulB = latched operands.
  - The multiplier registers the operands and zeroes its counters on this edge.
  - Next state: RUN.
- **RUN**
  - The window counter runs from 0 to 2^LOGLEN-1, one increment per cycle.
  - The ones counter adds iMulC each cycle.
  - Loads are held at 0. oMulA/oMulB hold their values.
  - On the cycle where the window counter reaches 2^LOGLEN-1, sample that cycle's iMulC, then go to DONE.
- **DONE**
  - oValid=1; oProd holds the final count.
  - On iValid&iReady… more precisely, on oValid&iReady, go to IDLE.
- **Width rules**
  - The ones counter is LOGLEN+1 bits and never wraps, since the maximum count is below 2^LOGLEN.
  - With LOGLEN=2*DATAWD, oProd = A*B exactly.
  - With a shorter window, oProd is the partial-window count, unscaled.
- **iFlush**
  - In LOAD, RUN or DONE, iFlush returns the FSM to IDLE on the next edge.
  - It discards the result: no oValid, counters cleared.
  - iFlush in IDLE has no effect.
  - iFlush has priority over every other transition, including DONE&iReady.
- **Acceptance**
  - oReady is low outside IDLE, so iValid there is ignored and not queued.
  - The next job is accepted in IDLE only, so there is no overlap between jobs.

## Timing
- **Reset values:** oReady=0 during the reset cycle, then 1. All other outputs are 0: oMulA, oMulB, oLoadA, oLoadB, oProd, oValid, oBusy.
- **Latency:** with the job accepted at edge t, oLoadA/B are high in cycle t+1.
- **RUN window:** iMulC is sampled in cycles t+2 .. t+1+2^LOGLEN.
- **Result:** oValid rises at cycle t+2+2^LOGLEN.
- **Throughput:** the minimum job-to-job interval is 2^LOGLEN+3 cycles, with iReady held high.
- **Result handshake:**
  - oProd and oValid stay stable until the cycle with iReady=1.
  - oValid drops on the following edge and oReady rises on that same edge.
- **Reset mid-job:** reset applies on the next edge from any state and aborts immediately. The multiplier is resynchronised by the next LOAD.

## Configuration
- **DMUL_SCHED_ZERO_SKIP_EN defined:**
  - If the latched iA==0 or iB==0 at acceptance, go IDLE→DONE directly with oProd=0.
  - oValid is high in cycle t+1, and no load pulse is issued.
- **Undefined:**
  - Zero operands take the full LOAD/RUN path.
  - oProd=0 at t+2+2^LOGLEN.

## Test plan
- Hold rst for 3 cycles → all outputs 0, with oReady=1 on the first cycle after release.
- iA=255, iB=255, default params → oLoadA/B high in cycle t+1; oValid at t+65538 with oProd=65025.
- iA=128, iB=64 → oProd=8192.
- Back-to-back: the next job is accepted in the IDLE cycle after DONE, and the result is correct.
- iA=0, iB=77:
  - With DMUL_SCHED_ZERO_SKIP_EN: oValid at t+1, oProd=0, no load pulse.
  - Without it: oValid at t+65538, oProd=0.
- Backpressure and flush:
  - Hold iReady low for 10 cycles in DONE → oProd stable, oReady=0, a concurrent iValid is ignored.
  - Assert iFlush in RUN cycle 1000 → IDLE next edge, oValid never asserts, oReady=1.

Source files
------------

// File: rtl/dmul_rot_sched.sv
// -----------------------------------------------------------------------------
// dmul_rot_sched
//
// Job scheduler for the rotation unary multiplier (dMUL_rot_uni). It turns the
// unary datapath into a blocking request/response binary multiplier:
//   1. IDLE  accept an operand pair on iValid/oReady.
//   2. LOAD  pulse oLoadA/oLoadB for one cycle with the latched operands.
//   3. RUN   count the ones on iMulC over a window of 2^LOGLEN cycles.
//   4. DONE  present the count on oProd/oValid until iReady.
//
// Parameters
//   DATAWD  operand width (must match the multiplier instance)
//   LOGLEN  log2 of the counting window, DATAWD..2*DATAWD
//           (LOGLEN = 2*DATAWD yields the exact product)
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   iA, iB, iValid   job request operands and strobe
//   oReady           high only in IDLE
//   iFlush           abort the current job (LOAD/RUN/DONE), result discarded
//   oMulA, oMulB     operands driven to the multiplier
//   oLoadA, oLoadB   multiplier load strobes (one-cycle pulse in LOAD)
//   iMulC            multiplier output bitstream
//   oProd, oValid    result count and strobe, held until iReady
//   iReady           result consumer ready
//   oBusy            high in every state except IDLE
//
// Optional feature
//   DMUL_SCHED_ZERO_SKIP_EN  when defined, a job with a zero operand skips
//                            LOAD/RUN and goes straight to DONE with oProd=0.
// -----------------------------------------------------------------------------
module dmul_rot_sched #(
  parameter int DATAWD = 8,
  parameter int LOGLEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATAWD-1:0] iA,
  input  logic [DATAWD-1:0] iB,
  input  logic              iValid,
  output logic              oReady,
  input  logic              iFlush,
  output logic [DATAWD-1:0] oMulA,
  output logic [DATAWD-1:0] oMulB,
  output logic              oLoadA,
  output logic              oLoadB,
  input  logic              iMulC,
  output logic [LOGLEN:0]   oProd,
  output logic              oValid,
  input  logic              iReady,
  output logic              oBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [LOGLEN-1:0] winCnt;   // cycles elapsed in the counting window
  logic [LOGLEN:0]   oneCnt;   // ones seen so far; one spare bit, never wraps
  logic [LOGLEN:0]   oneSum;   // ones count including this cycle's bit

  assign oneSum = oneCnt + {{LOGLEN{1'b0}}, iMulC};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      oReady <= 1'b0;
      oMulA  <= '0;
      oMulB  <= '0;
      oLoadA <= 1'b0;
      oLoadB <= 1'b0;
      oProd  <= '0;
      oValid <= 1'b0;
      oBusy  <= 1'b0;
      winCnt <= '0;
      oneCnt <= '0;
    end else begin
      // Load strobes are single-cycle pulses; only the accept branch raises them.
      oLoadA <= 1'b0;
      oLoadB <= 1'b0;

      case (state)
        IDLE: begin
          // oReady is registered, so the first IDLE cycle after reset shows 0.
          oReady <= 1'b1;
          if (iValid && oReady) begin
            oMulA  <= iA;
            oMulB  <= iB;
            winCnt <= '0;
            oneCnt <= '0;
            oReady <= 1'b0;
            oBusy  <= 1'b1;
`ifdef DMUL_SCHED_ZERO_SKIP_EN
            if (iA == '0 || iB == '0) begin
              // Product is known to be zero: no multiplier run needed.
              state  <= DONE;
              oProd  <= '0;
              oValid <= 1'b1;
            end else begin
              state  <= LOAD;
              oLoadA <= 1'b1;
              oLoadB <= 1'b1;
            end
`else
            state  <= LOAD;
            oLoadA <= 1'b1;
            oLoadB <= 1'b1;
`endif
          end
        end

        LOAD: begin
          // The multiplier captures operands and clears itself on this edge.
          if (iFlush) begin
            state  <= IDLE;
            oReady <= 1'b1;
            oBusy  <= 1'b0;
            winCnt <= '0;
            oneCnt <= '0;
          end else begin
            state <= RUN;
          end
        end

        RUN: begin
          if (iFlush) begin
            state  <= IDLE;
            oReady <= 1'b1;
            oBusy  <= 1'b0;
            winCnt <= '0;
            oneCnt <= '0;
          end else begin
            winCnt <= winCnt + 1'b1;
            oneCnt <= oneSum;
            // Last window cycle: its bitstream sample belongs to the result.
            if (winCnt == {LOGLEN{1'b1}}) begin
              state  <= DONE;
              oProd  <= oneSum;
              oValid <= 1'b1;
            end
          end
        end

        DONE: begin
          // Flush and a consumed result both end the job the same way; the
          // only difference is whether anyone saw oProd, so flush trivially wins.
          if (iFlush || iReady) begin
            state  <= IDLE;
            oValid <= 1'b0;
            oProd  <= '0;
            oReady <= 1'b1;
            oBusy  <= 1'b0;
            winCnt <= '0;
            oneCnt <= '0;
          end
        end

        default: begin
          state  <= IDLE;
          oReady <= 1'b0;
          oValid <= 1'b0;
          oBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmul_rot_sched.sv
// -----------------------------------------------------------------------------
// tb_dmul_rot_sched
//
// Runs the scheduler with DATAWD=4, LOGLEN=8 (exact product, 256-cycle window)
// so a full set of jobs fits in a short run. A small behavioural multiplier
// drives iMulC with exactly A*B ones per window. A timestamp-based job model
// predicts every output each cycle; directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_dmul_rot_sched;

  localparam int DW  = 4;
  localparam int LL  = 8;
  localparam int WIN = 1 << LL;
  localparam int TMO = 600;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] iA, iB;
  logic          iValid, iFlush, iReady, iMulC;
  logic          oReady, oLoadA, oLoadB, oValid, oBusy;
  logic [DW-1:0] oMulA, oMulB;
  logic [LL:0]   oProd;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dmul_rot_sched #(.DATAWD(DW), .LOGLEN(LL)) dut (
    .clk    (clk),
    .rst    (rst),
    .iA     (iA),
    .iB     (iB),
    .iValid (iValid),
    .oReady (oReady),
    .iFlush (iFlush),
    .oMulA  (oMulA),
    .oMulB  (oMulB),
    .oLoadA (oLoadA),
    .oLoadB (oLoadB),
    .iMulC  (iMulC),
    .oProd  (oProd),
    .oValid (oValid),
    .iReady (iReady),
    .oBusy  (oBusy)
  );

  task automatic chk(input string nm, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- multiplier stand-in ----------------
  // After a load, window cycle k emits a one when (k mod 2^DW) < A and
  // (k div 2^DW) < B, giving exactly A*B ones over 2^(2*DW) cycles.
  int            mk = 1000000;
  logic [DW-1:0] mA = '0, mB = '0;
  initial begin
    iMulC = 1'b0;
    forever begin
      @(negedge clk);
      if (oLoadA && oLoadB) begin
        mA = oMulA; mB = oMulB; mk = -1; iMulC = 1'b0;
      end else begin
        mk++;
        iMulC = (mk >= 0 && mk < WIN && (mk % (1 << DW)) < int'(mA)
                 && (mk / (1 << DW)) < int'(mB));
      end
    end
  end

  // ---------------- job model (timestamps, evaluated per edge) ----------------
  int   edgeN = 0, tAcc = 0, resCyc = 0, prodM = 0, aM = 0, bM = 0;
  bit   active = 0, skipM = 0, armed = 0, inRst = 0;
  bit   expReady = 0, expBusy = 0, expLoad = 0, expValid = 0;
  int   expProd = 0;
  initial begin
    forever begin
      @(posedge clk);
      edgeN++;
      inRst = rst;
      if (rst) begin
        active = 0; expReady = 0;
      end else begin
        if (active) begin
          if (iFlush) active = 0;
          else if (edgeN >= resCyc && iReady) active = 0;
        end else if (iValid && expReady) begin
          active = 1; tAcc = edgeN;
          aM = int'(iA); bM = int'(iB); prodM = aM * bM;
`ifdef DMUL_SCHED_ZERO_SKIP_EN
          skipM = (aM == 0 || bM == 0);
`else
          skipM = 0;
`endif
          resCyc = skipM ? tAcc + 1 : tAcc + 2 + WIN;
        end
        expReady = !active;
      end
      // expectations for the cycle that ends at edge edgeN+1
      expBusy  = active;
      expLoad  = active && !skipM && (edgeN == tAcc);
      expValid = active && (edgeN + 1 >= resCyc);
      expProd  = expValid ? prodM : 0;
      armed    = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("oReady", int'(oReady), int'(expReady));
        chk("oBusy",  int'(oBusy),  int'(expBusy));
        chk("oLoadA", int'(oLoadA), int'(expLoad));
        chk("oLoadB", int'(oLoadB), int'(expLoad));
        chk("oValid", int'(oValid), int'(expValid));
        if (expValid || inRst) chk("oProd", int'(oProd), expProd);
        if (expLoad) begin
          chk("oMulA", int'(oMulA), aM);
          chk("oMulB", int'(oMulB), bM);
        end
        if (inRst) begin
          chk("oMulA_rst", int'(oMulA), 0);
          chk("oMulB_rst", int'(oMulB), 0);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int negN = 0;
  always @(negedge clk) negN <= negN + 1;

  // Returns at the negedge of the cycle right after the accepting edge.
  task automatic submit(input int a, input int b, output int accNeg);
    int n;
    @(negedge clk);
    iA = DW'(a); iB = DW'(b); iValid = 1'b1;
    n = 0;
    while (!oReady && n < TMO) begin
      @(negedge clk); n++;
    end
    if (n >= TMO) chk("submit_timeout", 0, 1);
    accNeg = negN;
    @(negedge clk);
    iValid = 1'b0;
  endtask

  task automatic waitResult(output int lat, output int prod);
    lat = 1;
    while (!oValid && lat < TMO) begin
      @(negedge clk); lat++;
    end
    if (lat >= TMO) chk("result_timeout", 0, 1);
    prod = int'(oProd);
  endtask

  int lat, prod, t1, t2, seen;
  int expLat;

  initial begin
`ifdef DMUL_SCHED_ZERO_SKIP_EN
    expLat = 1;
`else
    expLat = WIN + 2;
`endif
    rst = 1'b1; iValid = 1'b0; iFlush = 1'b0; iReady = 1'b1; iA = '0; iB = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(oReady), 1);

    // max operands
    submit(15, 15, t1);
    chk("load_pulse_15x15", int'(oLoadA & oLoadB), 1);
    waitResult(lat, prod);
    chk("latency_15x15", lat, WIN + 2);
    chk("prod_15x15", prod, 225);
    $display("job 15x15 prod=%0d lat=%0d", prod, lat);

    // back-to-back: next job goes in the IDLE cycle after DONE
    submit(8, 4, t1);
    waitResult(lat, prod);
    chk("prod_8x4", prod, 32);
    $display("job 8x4 prod=%0d lat=%0d", prod, lat);
    submit(3, 5, t2);
    chk("job_interval", t2 - t1, WIN + 3);
    waitResult(lat, prod);
    chk("prod_3x5", prod, 15);
    $display("job 3x5 prod=%0d interval=%0d", prod, t2 - t1);

    // zero operand
    submit(0, 7, t1);
    chk("zero_load_pulse", int'(oLoadA), (expLat == 1) ? 0 : 1);
    waitResult(lat, prod);
    chk("latency_0x7", lat, expLat);
    chk("prod_0x7", prod, 0);
    $display("job 0x7 prod=%0d lat=%0d", prod, lat);

    // backpressure with a concurrent (ignored) request
    submit(9, 11, t1);
    iReady = 1'b0;
    waitResult(lat, prod);
    chk("prod_9x11", prod, 99);
    iA = 4'd1; iB = 4'd1; iValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_prod_stable", int'(oProd), 99);
      chk("bp_ready_low", int'(oReady), 0);
    end
    iValid = 1'b0; iReady = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(oReady), 1);
    $display("job 9x11 prod=%0d held 10 cycles", prod);

    // flush in RUN
    submit(13, 14, t1);
    repeat (100) @(negedge clk);
    iFlush = 1'b1;
    @(negedge clk);
    iFlush = 1'b0;
    chk("flush_run_ready", int'(oReady), 1);
    seen = 0;
    for (int i = 0; i < WIN + 10; i++) begin
      @(negedge clk);
      if (oValid) seen++;
    end
    chk("flush_run_no_valid", seen, 0);
    $display("job 13x14 flushed in RUN valid_seen=%0d", seen);

    // flush in LOAD
    submit(5, 5, t1);
    iFlush = 1'b1;
    @(negedge clk);
    iFlush = 1'b0;
    chk("flush_load_idle", int'(oBusy), 0);
    $display("job 5x5 flushed in LOAD busy=%0d", oBusy);

    // flush in DONE beats iReady
    submit(2, 3, t1);
    waitResult(lat, prod);
    iFlush = 1'b1;
    @(negedge clk);
    iFlush = 1'b0;
    chk("flush_done_valid", int'(oValid), 0);
    $display("job 2x3 flushed in DONE prod_seen=%0d", prod);

    // flush while idle does not block acceptance
    @(negedge clk);
    iA = 4'd6; iB = 4'd7; iValid = 1'b1; iFlush = 1'b1;
    @(negedge clk);
    iValid = 1'b0; iFlush = 1'b0;
    chk("flush_idle_accept", int'(oLoadA), 1);
    waitResult(lat, prod);
    chk("prod_6x7", prod, 42);
    $display("job 6x7 prod=%0d (flush in IDLE)", prod);

    // reset mid-job, then a clean job
    submit(10, 10, t1);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(oBusy), 0);
    submit(12, 12, t1);
    waitResult(lat, prod);
    chk("prod_12x12", prod, 144);
    $display("job 12x12 prod=%0d after mid-job reset", prod);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end

endmodule
